// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: host pixel/result handshakes and classifier-core window bus
interface cnn_frame_sequencer_if #(
  parameter int PIX_W = 8,
  parameter int K = 5
);
  logic                   START;
  logic                   BUSY;
  logic [PIX_W-1:0]       PIX_DATA;
  logic                   PIX_VALID;
  logic                   PIX_READY;
  logic                   CNN_START;
  logic [4:0]             CNN_X;
  logic [4:0]             CNN_Y;
  logic [K*K*PIX_W-1:0]   CNN_IMGIN;
  logic                   CNN_DONE;
  logic [3:0]             CNN_OUT;
  logic [3:0]             RES_DATA;
  logic                   RES_VALID;
  logic                   RES_READY;
  logic                   ERR;
  modport master (
    output START, PIX_DATA, PIX_VALID, CNN_DONE, CNN_OUT, RES_READY,
    input  BUSY, PIX_READY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, RES_DATA, RES_VALID, ERR
  );
  modport slave (
    input  START, PIX_DATA, PIX_VALID, CNN_DONE, CNN_OUT, RES_READY,
    output BUSY, PIX_READY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, RES_DATA, RES_VALID, ERR
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: buffers one frame, streams conv windows to the core, returns its class
module cnn_frame_sequencer #(
  parameter int IMG_W   = 28,
  parameter int K       = 5,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 64
) (
  input logic CLK,
  input logic nRST,
  cnn_frame_sequencer_if.slave bus
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int AW    = $clog2(NPIX);
  localparam int XW    = 5;
  localparam int WW    = K * K * PIX_W;
  localparam logic [XW-1:0] LST = XW'(OUT_W - 1);
  localparam logic [XW-1:0] ONE = XW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SCAN, WAIT_DONE, RESULT} state_t;

  state_t           st_q, st_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WW-1:0]    img_q, img_d;
  logic [3:0]       res_q, res_d;
  logic             rv_q, rv_d, err_q, err_d;
  logic [PIX_W-1:0] fb_q [NPIX];
  logic [XW-1:0]    nx, ny, mr, mc;
  logic [WW-1:0]    win;

  // position after the current X/Y; the mux looks one further ahead because IMGIN leads X/Y
  assign nx = (y_q == LST) ? x_q + ONE : x_q;
  assign ny = (y_q == LST) ? '0 : y_q + ONE;
  assign mr = (st_q == SCAN) ? ((ny == LST) ? nx + ONE : nx) : '0;
  assign mc = (st_q == SCAN) ? ((ny == LST) ? '0 : ny + ONE) : ((st_q == KICK) ? ONE : '0);

  for (genvar i = 0; i < K; i++) begin : g_r
    for (genvar j = 0; j < K; j++) begin : g_c
      assign win[(i*K+j)*PIX_W +: PIX_W] = fb_q[AW'((32'(mr) + i) * IMG_W + 32'(mc) + j)];
    end
  end

  // frame buffer fill, raster address from the pixel counter; contents survive reset
  always_ff @(posedge CLK)
    if (st_q == LOAD && bus.PIX_VALID) fb_q[cnt_q] <= bus.PIX_DATA;

  // next state: load, one kick cycle, 576 stall-free windows, wait for the core, hand off
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    img_d = img_q;
    res_d = res_q;
    rv_d  = rv_q;
    err_d = err_q;
    case (st_q)
      IDLE: if (bus.START) begin
        st_d  = LOAD;
        cnt_d = '0;
        err_d = 1'b0;
      end
      LOAD: if (bus.PIX_VALID) begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NPIX - 1)) begin
          st_d  = KICK;
          x_d   = '0;
          y_d   = '0;
          img_d = win;
        end
      end
      KICK: begin
        st_d  = SCAN;
        img_d = win;
      end
      SCAN: if (x_q == LST && y_q == LST) begin
        st_d  = WAIT_DONE;
        cnt_d = '0;
        img_d = '0;
      end else begin
        x_d   = nx;
        y_d   = ny;
        img_d = (nx == LST && ny == LST) ? '0 : win;
      end
      WAIT_DONE: if (bus.CNN_DONE) begin
        res_d = bus.CNN_OUT;
        rv_d  = 1'b1;
        st_d  = RESULT;
      end else if (cnt_q == AW'(TIMEOUT - 1)) begin
        err_d = 1'b1;
        st_d  = IDLE;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
      RESULT: if (bus.RES_READY) begin
        rv_d = 1'b0;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously together with the core
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      img_q <= '0;
      res_q <= '0;
      rv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      img_q <= img_d;
      res_q <= res_d;
      rv_q  <= rv_d;
      err_q <= err_d;
    end

  assign bus.BUSY      = st_q != IDLE;
  assign bus.PIX_READY = st_q == LOAD;
  assign bus.CNN_START = st_q == KICK;
  assign bus.CNN_X     = x_q;
  assign bus.CNN_Y     = y_q;
  assign bus.CNN_IMGIN = img_q;
  assign bus.RES_DATA  = res_q;
  assign bus.RES_VALID = rv_q;
  assign bus.ERR       = err_q;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: random/ramp frames against a window-schedule reference and core model
module tb_cnn_frame_sequencer;
  localparam int IMG_W = 28;
  localparam int OUT_W = 24;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int NWIN  = OUT_W * OUT_W;

  logic CLK = 1'b0;
  logic nRST;
  int checks = 0;
  int failures = 0;
  int core_mode = 0;
  logic [7:0] img [NPIX];

  cnn_frame_sequencer_if bus();
  cnn_frame_sequencer dut(.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [199:0] window(input int r, input int c);
    logic [199:0] w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = img[(r+i)*IMG_W + c + j];
    return w;
  endfunction

  // the core model sums byte 0 of every window, so the class is the 24x24 top-left pixel sum
  function automatic logic [3:0] expected_class();
    int s = 0;
    for (int r = 0; r < OUT_W; r++)
      for (int c = 0; c < OUT_W; c++)
        s += int'(img[r*IMG_W + c]);
    return 4'(s);
  endfunction

  // core model: mode 0 computes a class from the window stream, 1 answers 7, 2 never answers
  initial begin : core_model
    int acc;
    bus.CNN_DONE = 1'b0;
    bus.CNN_OUT  = 4'd0;
    forever begin
      @(negedge CLK);
      bus.CNN_DONE = 1'b0;
      if (bus.CNN_START === 1'b1) begin
        acc = 0;
        for (int n = 0; n < NWIN; n++) begin
          acc += int'(bus.CNN_IMGIN[7:0]);
          @(negedge CLK);
        end
        repeat (11) @(negedge CLK);
        if (core_mode != 2) begin
          bus.CNN_OUT  = (core_mode == 1) ? 4'd7 : 4'(acc);
          bus.CNN_DONE = 1'b1;
        end
      end
    end
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic ramp_image();
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
  endtask

  task automatic random_image();
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic start_frame();
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic send_pixels(input bit gaps);
    int idx = 0;
    int guard = 0;
    bit v;
    while (idx < NPIX && guard < 5000) begin
      v = gaps ? ($urandom_range(99) >= 30) : 1'b1;
      bus.PIX_VALID = v;
      bus.PIX_DATA  = v ? img[idx] : 8'($urandom);
      if (v && bus.PIX_READY) idx++;
      guard++;
      @(negedge CLK);
    end
    bus.PIX_VALID = 1'b0;
    checks++;
    if (idx != NPIX) begin
      failures++;
      $display("FAIL load: accepted %0d pixels, required %0d", idx, NPIX);
    end
  endtask

  // t=0 is KICK, t=1..576 is scan step k=t-1, t=577 is the first WAIT_DONE cycle
  task automatic check_trace();
    for (int t = 0; t <= NWIN + 1; t++) begin
      int k, ex, ey;
      logic es;
      logic [199:0] ew;
      k = t - 1;
      if (t == 0) begin
        es = 1'b1; ex = 0; ey = 0; ew = window(0, 0);
      end else if (t <= NWIN) begin
        es = 1'b0; ex = k / OUT_W; ey = k % OUT_W;
        ew = (k + 1 < NWIN) ? window((k + 1) / OUT_W, (k + 1) % OUT_W) : '0;
      end else begin
        es = 1'b0; ex = OUT_W - 1; ey = OUT_W - 1; ew = '0;
      end
      checks++;
      if (bus.CNN_START !== es || bus.CNN_X !== 5'(ex) || bus.CNN_Y !== 5'(ey) ||
          bus.CNN_IMGIN !== ew || bus.PIX_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
        failures++;
        $display("FAIL trace t=%0d: got start=%b x=%0d y=%0d ready=%b busy=%b imgin=%h, required start=%b x=%0d y=%0d ready=0 busy=1 imgin=%h",
                 t, bus.CNN_START, bus.CNN_X, bus.CNN_Y, bus.PIX_READY, bus.BUSY, bus.CNN_IMGIN, es, ex, ey, ew);
      end
      if (t <= NWIN) @(negedge CLK);
    end
  endtask

  task automatic finish_result(input logic [3:0] exp, input int hold, input bit poke_start);
    int lat = 0;
    while (bus.RES_VALID !== 1'b1 && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (lat != 11 || bus.RES_DATA !== exp) begin
      failures++;
      $display("FAIL result: latency=%0d data=%0d, required latency=11 data=%0d", lat, bus.RES_DATA, exp);
    end
    repeat (hold) begin
      if (poke_start) bus.START = 1'($urandom_range(1));
      @(negedge CLK);
      checks++;
      if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== exp || bus.BUSY !== 1'b1) begin
        failures++;
        $display("FAIL result_hold: valid=%b data=%0d busy=%b, required valid=1 data=%0d busy=1",
                 bus.RES_VALID, bus.RES_DATA, bus.BUSY, exp);
      end
    end
    if (poke_start) bus.START = 1'b1;
    bus.RES_READY = 1'b1;
    @(negedge CLK);
    bus.RES_READY = 1'b0;
    if (poke_start) bus.START = 1'b0;
    checks++;
    if (bus.RES_VALID !== 1'b0 || bus.RES_DATA !== exp || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL result_release: valid=%b data=%0d busy=%b, required valid=0 data=%0d busy=0",
               bus.RES_VALID, bus.RES_DATA, bus.BUSY, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.BUSY, bus.PIX_READY, bus.CNN_START, bus.CNN_X, bus.CNN_Y, bus.CNN_IMGIN,
         bus.RES_DATA, bus.RES_VALID, bus.ERR} !== '0) begin
      failures++;
      $display("FAIL %s: busy=%b ready=%b start=%b x=%0d y=%0d imgin=%h res=%0d valid=%b err=%b, required all zero",
               name, bus.BUSY, bus.PIX_READY, bus.CNN_START, bus.CNN_X, bus.CNN_Y, bus.CNN_IMGIN,
               bus.RES_DATA, bus.RES_VALID, bus.ERR);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (3) @(negedge CLK);
    check_all_zero("reset_held");
    nRST = 1'b1;
    @(negedge CLK);
    check_all_zero("reset_idle");
  endtask

  task automatic test_ramp();
    ramp_image();
    start_frame();
    send_pixels(1'b0);
    check_trace();
    finish_result(expected_class(), 0, 1'b0);
  endtask

  task automatic test_gaps();
    ramp_image();
    checks++;
    if (bus.PIX_READY !== 1'b0) begin
      failures++;
      $display("FAIL ready_idle: ready=%b, required 0", bus.PIX_READY);
    end
    start_frame();
    send_pixels(1'b1);
    check_trace();
    finish_result(expected_class(), 0, 1'b0);
  endtask

  task automatic test_result_hold();
    random_image();
    core_mode = 1;
    start_frame();
    send_pixels(1'b1);
    check_trace();
    finish_result(4'd7, 20, 1'b1);
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.PIX_READY !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored: busy=%b ready=%b, required busy=0 ready=0", bus.BUSY, bus.PIX_READY);
    end
    core_mode = 0;
  endtask

  task automatic test_timeout();
    random_image();
    core_mode = 2;
    start_frame();
    send_pixels(1'b0);
    check_trace();
    repeat (63) @(negedge CLK);
    checks++;
    if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%b busy=%b, required err=0 busy=1", bus.ERR, bus.BUSY);
    end
    @(negedge CLK);
    checks++;
    if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0 || bus.RES_VALID !== 1'b0) begin
      failures++;
      $display("FAIL timeout: err=%b busy=%b valid=%b, required err=1 busy=0 valid=0", bus.ERR, bus.BUSY, bus.RES_VALID);
    end
    @(negedge CLK);
    bus.START = 1'b1;
    checks++;
    if (bus.ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b, required 1", bus.ERR);
    end
    @(negedge CLK);
    bus.START = 1'b0;
    checks++;
    if (bus.ERR !== 1'b0 || bus.PIX_READY !== 1'b1) begin
      failures++;
      $display("FAIL err_clear: err=%b ready=%b, required err=0 ready=1", bus.ERR, bus.PIX_READY);
    end
    core_mode = 0;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    random_image();
    start_frame();
    send_pixels(1'b0);
    repeat (301) @(negedge CLK);
    checks++;
    if (bus.CNN_X !== 5'd12 || bus.CNN_Y !== 5'd12) begin
      failures++;
      $display("FAIL scan_k300: x=%0d y=%0d, required x=12 y=12", bus.CNN_X, bus.CNN_Y);
    end
    #2 nRST = 1'b0;
    #1 check_all_zero("reset_mid_scan");
    @(negedge CLK);
    nRST = 1'b1;
    random_image();
    start_frame();
    send_pixels(1'b1);
    check_trace();
    finish_result(expected_class(), 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a;
    random_image();
    exp_a = expected_class();
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    send_pixels(1'b0);
    check_trace();
    finish_result(exp_a, 3, 1'b0);
    checks++;
    if (bus.PIX_READY !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: ready=%b, required 0", bus.PIX_READY);
    end
    random_image();
    @(negedge CLK);
    checks++;
    if (bus.PIX_READY !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reload: ready=%b, required 1", bus.PIX_READY);
    end
    send_pixels(1'b1);
    bus.START = 1'b0;
    check_trace();
    finish_result(expected_class(), 2, 1'b0);
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.PIX_DATA  = 8'd0;
    bus.PIX_VALID = 1'b0;
    bus.RES_READY = 1'b0;
    test_reset();
    test_ramp();
    test_gaps();
    test_result_hold();
    test_timeout();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
